// File: rtl/ips_hsst_rst_pkg.sv
// Shared definitions for the HSST lane reset sequencers: state encoding,
// default cycle counts, the Moore output decode and counter sizing helpers.
package ips_hsst_rst_pkg;

    // Raw state encoding, kept as plain constants so other blocks and
    // debug logic can compare against the same values.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PMA_RST  = 3'd1;
    localparam logic [2:0] ST_WAIT_CDR = 3'd2;
    localparam logic [2:0] ST_PCS_RST  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        PMA_RST  = ST_PMA_RST,
        WAIT_CDR = ST_WAIT_CDR,
        PCS_RST  = ST_PCS_RST,
        DONE     = ST_DONE
    } rx_rst_state_e;

    // Default cycle counts for a production lane.
    localparam int DEF_PMA_RST_CYC   = 32;
    localparam int DEF_DEBOUNCE_CYC  = 8;
    localparam int DEF_LOCK_WAIT_CYC = 2048;
    localparam int DEF_PCS_RST_CYC   = 16;

    // The three level outputs that follow the state.
    typedef struct packed {
        logic pma_rst;
        logic pcs_rst;
        logic rst_done;
    } rx_rst_outs_t;

    // Bits needed to hold any value from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Output levels for each state. PMA reset is only released once the
    // PLL has been locked long enough; PCS reset is released last.
    function automatic rx_rst_outs_t state_outputs(input rx_rst_state_e s);
        rx_rst_outs_t o;
        o = '{pma_rst: 1'b1, pcs_rst: 1'b1, rst_done: 1'b0};
        case (s)
            IDLE:     o = '{pma_rst: 1'b1, pcs_rst: 1'b1, rst_done: 1'b0};
            PMA_RST:  o = '{pma_rst: 1'b1, pcs_rst: 1'b1, rst_done: 1'b0};
            WAIT_CDR: o = '{pma_rst: 1'b0, pcs_rst: 1'b1, rst_done: 1'b0};
            PCS_RST:  o = '{pma_rst: 1'b0, pcs_rst: 1'b1, rst_done: 1'b0};
            DONE:     o = '{pma_rst: 1'b0, pcs_rst: 1'b0, rst_done: 1'b1};
            default:  o = '{pma_rst: 1'b1, pcs_rst: 1'b1, rst_done: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ips_hsst_lock_debounce.sv
// Saturating consecutive-high counter used to qualify CDR lock.
// 'stable' is high in the cycle whose sample brings the run of consecutive
// high samples up to DEBOUNCE_CYC, so the parent can change state on that
// same edge without waiting an extra cycle for a registered flag.
module ips_hsst_lock_debounce
    import ips_hsst_rst_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic level,
    output logic stable
);

    localparam int              DB_W   = cnt_width(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC);

    logic [DB_W-1:0] count;
    logic [DB_W-1:0] count_nxt;

    // Next run length: any low sample or a clear restarts the run, otherwise
    // count up and stick at the threshold.
    always_comb begin
        count_nxt = '0;
        if (!clear && level) begin
            if (count == DB_MAX) begin
                count_nxt = DB_MAX;
            end else begin
                count_nxt = count + DB_W'(1);
            end
        end
    end

    // Run-length register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    assign stable = (count_nxt == DB_MAX);

endmodule

// File: rtl/ips_hsst_rx_rst_fsm_v1_0.sv
// Receive-side HSST reset sequencer. Walks the lane RX out of reset in
// order: PLL lock, PMA reset hold, debounced CDR lock with timeout, PCS
// reset hold, then done. All outputs are registered with the state so
// nothing downstream sees a combinational path from the lock inputs.
module ips_hsst_rx_rst_fsm_v1_0
    import ips_hsst_rst_pkg::*;
#(
    parameter int PMA_RST_CYC   = DEF_PMA_RST_CYC,
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int LOCK_WAIT_CYC = DEF_LOCK_WAIT_CYC,
    parameter int PCS_RST_CYC   = DEF_PCS_RST_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock_synced,
    input  logic sigdet_synced,
    input  logic cdr_lock_synced,
    input  logic force_rst,
    output logic rx_pma_rst,
    output logic rx_pcs_rst,
    output logic rx_rst_done,
    output logic rx_timeout
);

    // One down-counter is shared by the PMA hold, the CDR timeout and the
    // PCS hold, so it is sized for the largest of them.
    localparam int CNT_MAX = max_of(max_of(PMA_RST_CYC, DEBOUNCE_CYC),
                                    max_of(LOCK_WAIT_CYC, PCS_RST_CYC));
    localparam int CNT_W   = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] PMA_LOAD  = CNT_W'(PMA_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] PCS_LOAD  = CNT_W'(PCS_RST_CYC - 1);

    rx_rst_state_e    state;
    rx_rst_state_e    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_nxt;
    rx_rst_outs_t     outs;

    logic             db_clear;
    logic             db_stable;
    logic             link_ok;

    // The debounce run only accumulates while waiting for CDR; any other
    // state holds it at zero so every WAIT_CDR visit starts a fresh run.
    assign db_clear = (state != WAIT_CDR);
    assign link_ok  = cdr_lock_synced & sigdet_synced;

    ips_hsst_lock_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_cdr_debounce (
        .clk    (clk),
        .rst    (rst),
        .clear  (db_clear),
        .level  (link_ok),
        .stable (db_stable)
    );

    // Next-state and counter decision. Soft reset and PLL loss override
    // everything; within a state, loss of lock beats counter expiry, and
    // a debounce that completes on the timeout cycle still counts as lock.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;

        if (force_rst) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if ((state != IDLE) && !pll_lock_synced) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pll_lock_synced) begin
                        state_nxt = PMA_RST;
                        cnt_nxt   = PMA_LOAD;
                    end
                end

                PMA_RST: begin
                    if (cnt == '0) begin
                        state_nxt = WAIT_CDR;
                        cnt_nxt   = LOCK_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end

                WAIT_CDR: begin
                    if (db_stable) begin
                        state_nxt = PCS_RST;
                        cnt_nxt   = PCS_LOAD;
                    end else if (cnt == '0) begin
                        state_nxt   = PMA_RST;
                        cnt_nxt     = PMA_LOAD;
                        timeout_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end

                PCS_RST: begin
                    if (!cdr_lock_synced) begin
                        state_nxt = PMA_RST;
                        cnt_nxt   = PMA_LOAD;
                    end else if (cnt == '0) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    if (!sigdet_synced || !cdr_lock_synced) begin
                        state_nxt = PMA_RST;
                        cnt_nxt   = PMA_LOAD;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter and outputs update together so the outputs always
    // describe the state that was just entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            outs       <= state_outputs(IDLE);
            rx_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            outs       <= state_outputs(state_nxt);
            rx_timeout <= timeout_nxt;
        end
    end

    assign rx_pma_rst  = outs.pma_rst;
    assign rx_pcs_rst  = outs.pcs_rst;
    assign rx_rst_done = outs.rst_done;

endmodule

// File: tb/tb_ips_hsst_rx_rst_fsm_v1_0.sv
// Self-checking bench for the RX reset sequencer. A cycle-level model of
// the bring-up rules (elapsed-time and lock-run counters) predicts every
// output each cycle, alongside directed timing checks and random traffic.
module tb_ips_hsst_rx_rst_fsm_v1_0;

    localparam int P_PMA  = 4;
    localparam int P_DEB  = 3;
    localparam int P_WAIT = 20;
    localparam int P_PCS  = 2;

    // Model phases, named by what the lane is doing.
    localparam int M_OFF   = 0;
    localparam int M_PMA   = 1;
    localparam int M_WAIT  = 2;
    localparam int M_PCS   = 3;
    localparam int M_READY = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_lock_synced = 1'b0;
    logic sigdet_synced = 1'b0;
    logic cdr_lock_synced = 1'b0;
    logic force_rst = 1'b0;
    logic rx_pma_rst;
    logic rx_pcs_rst;
    logic rx_rst_done;
    logic rx_timeout;

    int    checks = 0;
    int    failures = 0;
    string scen = "init";

    int   mPhase = M_OFF;
    int   mDwell = 0;
    int   mRun = 0;
    logic mTimeout = 1'b0;

    logic debPattern [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    ips_hsst_rx_rst_fsm_v1_0 #(
        .PMA_RST_CYC   (P_PMA),
        .DEBOUNCE_CYC  (P_DEB),
        .LOCK_WAIT_CYC (P_WAIT),
        .PCS_RST_CYC   (P_PCS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_lock_synced (pll_lock_synced),
        .sigdet_synced   (sigdet_synced),
        .cdr_lock_synced (cdr_lock_synced),
        .force_rst       (force_rst),
        .rx_pma_rst      (rx_pma_rst),
        .rx_pcs_rst      (rx_pcs_rst),
        .rx_rst_done     (rx_rst_done),
        .rx_timeout      (rx_timeout)
    );

    // Free-running lane clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s/%s: got %0d, expected %0d", scen, tag, observed, expected);
        end
    endtask

    // Behavioural bring-up rules, advanced once per rising edge.
    function automatic void modelStep(input logic r, input logic f, input logic p,
                                      input logic s, input logic c);
        mTimeout = 1'b0;
        if (r || f) begin
            mPhase = M_OFF;
            mDwell = 0;
            mRun   = 0;
        end else if (mPhase != M_OFF && !p) begin
            mPhase = M_OFF;
            mDwell = 0;
            mRun   = 0;
        end else begin
            case (mPhase)
                M_OFF: begin
                    if (p) begin
                        mPhase = M_PMA;
                        mDwell = 0;
                    end
                end
                M_PMA: begin
                    mDwell++;
                    if (mDwell == P_PMA) begin
                        mPhase = M_WAIT;
                        mDwell = 0;
                        mRun   = 0;
                    end
                end
                M_WAIT: begin
                    mDwell++;
                    mRun = (c && s) ? ((mRun < P_DEB) ? mRun + 1 : P_DEB) : 0;
                    if (mRun == P_DEB) begin
                        mPhase = M_PCS;
                        mDwell = 0;
                    end else if (mDwell == P_WAIT) begin
                        mPhase   = M_PMA;
                        mDwell   = 0;
                        mTimeout = 1'b1;
                    end
                end
                M_PCS: begin
                    if (!c) begin
                        mPhase = M_PMA;
                        mDwell = 0;
                    end else begin
                        mDwell++;
                        if (mDwell == P_PCS) begin
                            mPhase = M_READY;
                        end
                    end
                end
                default: begin
                    if (!s || !c) begin
                        mPhase = M_PMA;
                        mDwell = 0;
                    end
                end
            endcase
        end
    endfunction

    // Drive one cycle of inputs, step the model on the edge, then compare
    // all four outputs half a cycle later.
    task automatic applyStimulus(input logic r, input logic f, input logic p,
                                 input logic s, input logic c);
        rst             = r;
        force_rst       = f;
        pll_lock_synced = p;
        sigdet_synced   = s;
        cdr_lock_synced = c;
        @(posedge clk);
        modelStep(r, f, p, s, c);
        @(negedge clk);
        checkOutput("pma_rst", rx_pma_rst, (mPhase == M_OFF || mPhase == M_PMA) ? 1 : 0);
        checkOutput("pcs_rst", rx_pcs_rst, (mPhase != M_READY) ? 1 : 0);
        checkOutput("rst_done", rx_rst_done, (mPhase == M_READY) ? 1 : 0);
        checkOutput("timeout", rx_timeout, mTimeout);
    endtask

    initial begin
        int   doneAt;
        int   pmaLowAt;
        int   pcsLowAt;
        int   pmaHigh;
        int   firstPulse;
        int   pulseCount;
        logic sawTimeout;
        logic cdrDead;
        logic r, f, p, s, c;

        // Reset with every lock input already high.
        scen = "reset";
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("reset_pma", rx_pma_rst, 1);
        checkOutput("reset_done", rx_rst_done, 0);

        // Nominal bring-up right after reset release.
        scen = "nominal";
        doneAt = -1; pmaLowAt = -1; pcsLowAt = -1; pmaHigh = 0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            if (rx_pma_rst) pmaHigh++;
            if (pmaLowAt < 0 && !rx_pma_rst) pmaLowAt = i;
            if (pcsLowAt < 0 && !rx_pcs_rst) pcsLowAt = i;
            if (doneAt < 0 && rx_rst_done) doneAt = i;
        end
        checkOutput("pma_cycles", pmaHigh, P_PMA);
        checkOutput("pcs_after_pma", pcsLowAt - pmaLowAt, P_DEB + P_PCS);
        checkOutput("done_cycle", doneAt, 1 + P_PMA + P_DEB + P_PCS);

        // CDR never locks: repeated timeouts and PMA retries.
        scen = "timeout";
        firstPulse = -1; pulseCount = 0;
        for (int i = 1; i <= 60; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            if (rx_timeout) begin
                pulseCount++;
                if (firstPulse < 0) firstPulse = i;
            end
        end
        checkOutput("first_pulse", firstPulse, 1 + P_PMA + P_WAIT);
        checkOutput("pulse_count", pulseCount, 2);

        // Interrupted lock run only counts once three consecutive highs land.
        scen = "debounce";
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (1 + P_PMA) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        doneAt = -1;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, (i <= 6) ? debPattern[i-1] : 1'b1);
            if (doneAt < 0 && rx_rst_done) doneAt = i;
        end
        checkOutput("done_cycle", doneAt, 6 + P_PCS);

        // Brief signal-detect loss while done, then rerun, then PLL loss.
        scen = "loss";
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("drop_pma", rx_pma_rst, 1);
        checkOutput("drop_done", rx_rst_done, 0);
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Hard reset and soft reset while holding PCS reset.
        scen = "rst_in_pcs";
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (1 + P_PMA + P_DEB) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("pcs_after_rst", rx_pcs_rst, 1);
        scen = "force_in_pcs";
        repeat (1 + P_PMA + P_DEB) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("pma_after_force", rx_pma_rst, 1);
        scen = "force_held";
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Debounce completes on the very cycle the lock wait runs out.
        scen = "tie";
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (1 + P_PMA) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        sawTimeout = 1'b0;
        doneAt = -1;
        for (int i = 1; i <= P_WAIT + P_PCS + 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, (i > P_WAIT - P_DEB) ? 1'b1 : 1'b0);
            if (rx_timeout) sawTimeout = 1'b1;
            if (doneAt < 0 && rx_rst_done) doneAt = i;
        end
        checkOutput("no_timeout", sawTimeout, 0);
        checkOutput("done_cycle", doneAt, P_WAIT + P_PCS);

        // Random traffic with occasional long CDR outages.
        scen = "random";
        cdrDead = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 79) == 0) cdrDead = ~cdrDead;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 149) == 0);
            p = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 59) != 0);
            c = cdrDead ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 19) != 0);
            applyStimulus(r, f, p, s, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
